wasm_bulk_mem: RTL and testbench

Sequencer for WebAssembly bulk-memory instructions memory.fill and memory.copy. It sits directly upstream of the linear memory, between the execute stage and the memory read/write ports. It runs the whole bounds check before any write, then drives one byte per cycle into the memory and reports completion or a trap back to the execute stage.

---
 rtl/wasm_bulk_mem.sv | 179 +++++++++++++++++
 tb/tb_wasm_bulk_mem.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wasm_bulk_mem.sv
// Bulk-memory sequencer for memory.fill / memory.copy: full bounds check first, then one byte per cycle.
// Codes: TRAP_NONE=0, TRAP_OUT_OF_BOUNDS=2, MEM_LOAD_I8_U=2, MEM_STORE_I8=7 (4-bit trap_t / mem_op_t).
module wasm_bulk_mem #(
   parameter int unsigned PAGE_BYTES = 65536
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] dst,
   input  logic [31:0] src,
   input  logic [7:0]  val,
   input  logic [31:0] len,
   input  logic [31:0] current_pages,
   output logic        busy,
   output logic        done,
   output logic [3:0]  trap_o,
   output logic        mem_rd_en,
   output logic [31:0] mem_rd_addr,
   output logic [3:0]  mem_rd_op,
   input  logic [63:0] mem_rd_data,
   output logic        mem_wr_en,
   output logic [31:0] mem_wr_addr,
   output logic [3:0]  mem_wr_op,
   output logic [63:0] mem_wr_data,
   input  logic [3:0]  mem_trap
);

   localparam logic [3:0] TRAP_NONE          = 4'd0;
   localparam logic [3:0] TRAP_OUT_OF_BOUNDS = 4'd2;
   localparam logic [3:0] MEM_LOAD_I8_U      = 4'd2;
   localparam logic [3:0] MEM_STORE_I8       = 4'd7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_FILL,
      S_COPY_FWD,
      S_COPY_BWD,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        op_q, op_d;
   logic [31:0] wptr_q, wptr_d;
   logic [31:0] rptr_q, rptr_d;
   logic [31:0] rem_q, rem_d;
   logic [7:0]  val_q, val_d;
   logic [3:0]  trap_q, trap_d;

   logic [32:0] limit;
   logic [32:0] dend;
   logic [32:0] send;
   logic        oob;
   logic        in_fill;
   logic        in_copy;
   logic        unused_rd_hi;

   // Upper read-data lanes are irrelevant for byte transfers.
   assign unused_rd_hi = ^mem_rd_data[63:8];

   assign limit = 33'(current_pages) * 33'(PAGE_BYTES);
   assign dend  = {1'b0, wptr_q} + {1'b0, rem_q};
   assign send  = {1'b0, rptr_q} + {1'b0, rem_q};
   assign oob   = (dend > limit) || (op_q && (send > limit));

   assign in_fill = (state_q == S_FILL);
   assign in_copy = (state_q == S_COPY_FWD) || (state_q == S_COPY_BWD);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= 1'b0;
         wptr_q  <= 32'd0;
         rptr_q  <= 32'd0;
         rem_q   <= 32'd0;
         val_q   <= 8'd0;
         trap_q  <= TRAP_NONE;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         rem_q   <= rem_d;
         val_q   <= val_d;
         trap_q  <= trap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      rem_d   = rem_q;
      val_d   = val_q;
      trap_d  = trap_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               wptr_d  = dst;
               rptr_d  = src;
               rem_d   = len;
               val_d   = val;
               trap_d  = TRAP_NONE;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (oob) begin
               trap_d  = TRAP_OUT_OF_BOUNDS;
               state_d = S_DONE;
            end else if (rem_q == 32'd0) begin
               state_d = S_DONE;
            end else if (!op_q) begin
               state_d = S_FILL;
            end else if (wptr_q > rptr_q) begin
               // Descending order keeps overlapping copies with dst > src correct.
               wptr_d  = wptr_q + rem_q - 32'd1;
               rptr_d  = rptr_q + rem_q - 32'd1;
               state_d = S_COPY_BWD;
            end else begin
               state_d = S_COPY_FWD;
            end
         end
         S_FILL, S_COPY_FWD, S_COPY_BWD: begin
            if (mem_trap != TRAP_NONE) begin
               trap_d  = mem_trap;
               state_d = S_DONE;
            end else begin
               rem_d = rem_q - 32'd1;
               if (state_q == S_COPY_BWD) begin
                  wptr_d = wptr_q - 32'd1;
                  rptr_d = rptr_q - 32'd1;
               end else begin
                  wptr_d = wptr_q + 32'd1;
                  rptr_d = rptr_q + 32'd1;
               end
               if (rem_q == 32'd1) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Enables are masked by rst so an aborting edge commits nothing.
   always_comb begin
      busy        = (state_q != S_IDLE);
      done        = (state_q == S_DONE);
      trap_o      = trap_q;
      mem_rd_op   = MEM_LOAD_I8_U;
      mem_wr_op   = MEM_STORE_I8;
      mem_rd_en   = 1'b0;
      mem_rd_addr = 32'd0;
      mem_wr_en   = 1'b0;
      mem_wr_addr = 32'd0;
      mem_wr_data = 64'd0;
      if (in_fill) begin
         mem_wr_en   = !rst;
         mem_wr_addr = wptr_q;
         mem_wr_data = {56'd0, val_q};
      end else if (in_copy) begin
         mem_rd_en   = !rst;
         mem_rd_addr = rptr_q;
         mem_wr_en   = !rst;
         mem_wr_addr = wptr_q;
         mem_wr_data = {56'd0, mem_rd_data[7:0]};
      end
   end

endmodule

// File: tb/tb_wasm_bulk_mem.sv
// Bench for wasm_bulk_mem: byte-array memory, memmove-style reference model, directed and random ops.
module tb_wasm_bulk_mem;

   localparam int MEMSZ = 2 * 65536 + 64;
   localparam logic [3:0] T_NONE = 4'd0;
   localparam logic [3:0] T_OOB  = 4'd2;
   localparam logic [3:0] OP_LD8U = 4'd2;
   localparam logic [3:0] OP_ST8  = 4'd7;

   logic        clk = 1'b0;
   logic        rst, start, op;
   logic [31:0] dst, src, len, current_pages;
   logic [7:0]  val;
   logic        busy, done, mem_rd_en, mem_wr_en;
   logic [3:0]  trap_o, mem_rd_op, mem_wr_op, mem_trap;
   logic [31:0] mem_rd_addr, mem_wr_addr;
   logic [63:0] mem_rd_data, mem_wr_data;

   logic [7:0]  mem     [MEMSZ];
   logic [7:0]  ref_mem [MEMSZ];
   logic [31:0] wr_log[$];
   logic [31:0] exp_addrs[$];

   logic        inj_en;
   logic [31:0] inj_addr;
   logic [3:0]  inj_code;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   wasm_bulk_mem #(.PAGE_BYTES(65536)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .dst(dst), .src(src), .val(val),
      .len(len), .current_pages(current_pages), .busy(busy), .done(done), .trap_o(trap_o),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_op(mem_rd_op),
      .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
      .mem_wr_op(mem_wr_op), .mem_wr_data(mem_wr_data), .mem_trap(mem_trap)
   );

   // Upper lanes carry junk so a design that forwards them is caught.
   assign mem_rd_data = (mem_rd_addr < MEMSZ) ? {56'hA5A5A5_A5A5A5A5, mem[mem_rd_addr]}
                                              : 64'hFFFF_FFFF_FFFF_FFFF;
   assign mem_trap = (inj_en && mem_wr_en && mem_wr_addr == inj_addr) ? inj_code : T_NONE;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      if (mem_wr_en === 1'b1) begin
         wr_log.push_back(mem_wr_addr);
         chk("wr_data_hi", {8'd0, mem_wr_data[63:8]}, 64'd0);
         chk("wr_op", mem_wr_op, OP_ST8);
         if (mem_trap == T_NONE && mem_wr_addr < MEMSZ) mem[mem_wr_addr] = mem_wr_data[7:0];
      end
      if (mem_rd_en === 1'b1) chk("rd_op", mem_rd_op, OP_LD8U);
   end

   function automatic int mem_diff();
      int n = 0;
      for (int i = 0; i < MEMSZ; i++) if (mem[i] !== ref_mem[i]) n++;
      return n;
   endfunction

   // Reference: memmove semantics with 64-bit bounds arithmetic.
   task automatic model(input bit o, input logic [31:0] d, input logic [31:0] s, input logic [7:0] v,
                        input logic [31:0] l, input logic [31:0] pg,
                        output logic [3:0] etrap, output int ecyc);
      longint unsigned lim = longint'(pg) * 65536;
      logic [7:0] tmp[$];
      exp_addrs.delete();
      if ((longint'(d) + longint'(l) > lim) || (o && (longint'(s) + longint'(l) > lim))) begin
         etrap = T_OOB;
         ecyc  = 2;
         return;
      end
      etrap = T_NONE;
      ecyc  = (l == 0) ? 2 : int'(l) + 2;
      for (int i = 0; i < int'(l); i++) tmp.push_back(o ? ref_mem[s + i] : v);
      for (int i = 0; i < int'(l); i++) ref_mem[d + i] = tmp[i];
      for (int i = 0; i < int'(l); i++)
         exp_addrs.push_back((o && d > s) ? d + l - 1 - i : d + i);
   endtask

   task automatic issue(input bit o, input logic [31:0] d, input logic [31:0] s, input logic [7:0] v,
                        input logic [31:0] l, input logic [31:0] pg);
      start = 1'b1; op = o; dst = d; src = s; val = v; len = l; current_pages = pg;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_op(input string tag, input bit o, input logic [31:0] d, input logic [31:0] s,
                         input logic [7:0] v, input logic [31:0] l, input logic [31:0] pg);
      logic [3:0] etrap;
      int ecyc, c, nbad;
      model(o, d, s, v, l, pg, etrap, ecyc);
      wr_log.delete();
      issue(o, d, s, v, l, pg);
      c = 1;
      chk({tag, " check_busy"}, busy, 1);
      chk({tag, " check_no_wr"}, mem_wr_en, 0);
      while (done !== 1'b1 && c < 64) begin
         @(posedge clk); #1;
         c++;
      end
      chk({tag, " done_seen"}, done, 1);
      chk({tag, " done_cycle"}, c, ecyc);
      chk({tag, " trap"}, trap_o, etrap);
      chk({tag, " done_no_wr"}, {mem_rd_en, mem_wr_en}, 0);
      @(posedge clk); #1;
      chk({tag, " idle_after"}, {busy, done}, 0);
      chk({tag, " wr_count"}, wr_log.size(), exp_addrs.size());
      nbad = 0;
      for (int i = 0; i < wr_log.size() && i < exp_addrs.size(); i++)
         if (wr_log[i] !== exp_addrs[i]) nbad++;
      chk({tag, " wr_order"}, nbad, 0);
      chk({tag, " mem_image"}, mem_diff(), 0);
      $display("%s op=%0d dst=%h src=%h len=%h pages=%0d trap=%0d cycles=%0d writes=%0d",
               tag, o, d, s, l, pg, trap_o, c, wr_log.size());
   endtask

   task automatic preload8();
      for (int i = 0; i < 8; i++) begin
         mem[i] = 8'(i);
         ref_mem[i] = 8'(i);
      end
   endtask

   initial begin
      logic [7:0] exp8[8];
      logic [31:0] pg, lim, d, s, l;
      int nbad, c;
      bit saw_done;

      rst = 1'b1; start = 1'b0; op = 1'b0; dst = 0; src = 0; val = 0; len = 0; current_pages = 0;
      inj_en = 1'b0; inj_addr = 0; inj_code = 0;
      for (int i = 0; i < MEMSZ; i++) begin
         mem[i] = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy/done", {busy, done}, 0);
      chk("reset trap", trap_o, T_NONE);
      chk("reset enables", {mem_rd_en, mem_wr_en}, 0);
      chk("reset addrs", {mem_rd_addr, mem_wr_addr}, 0);
      chk("reset wr_data", mem_wr_data, 0);
      $display("reset busy=%0d done=%0d trap=%0d", busy, done, trap_o);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op("fill_basic", 0, 32'h10, 0, 8'hAB, 4, 1);
      chk("fill_basic byte13", mem[32'h13], 8'hAB);

      preload8();
      run_op("copy_bwd", 1, 2, 0, 8'h00, 6, 1);
      exp8 = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      nbad = 0;
      for (int i = 0; i < 8; i++) if (mem[i] !== exp8[i]) nbad++;
      chk("copy_bwd literal", nbad, 0);
      chk("copy_bwd first_addr", (wr_log.size() > 0) ? wr_log[0] : 32'hFFFF_FFFF, 7);

      preload8();
      run_op("copy_fwd", 1, 0, 2, 8'h00, 6, 1);
      exp8 = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h06, 8'h07};
      nbad = 0;
      for (int i = 0; i < 8; i++) if (mem[i] !== exp8[i]) nbad++;
      chk("copy_fwd literal", nbad, 0);

      run_op("oob_fill", 0, 32'hFFFC, 0, 8'h99, 8, 1);
      run_op("oob_wrap", 1, 0, 32'hFFFF_FFFF, 8'h00, 2, 1);
      run_op("len0_edge", 0, 32'h1_0000, 0, 8'h44, 0, 1);
      run_op("len0_over", 0, 32'h1_0001, 0, 8'h44, 0, 1);
      run_op("fill_to_limit", 0, 32'hFFFC, 0, 8'h3C, 4, 1);

      // Reset during the third transfer: only two bytes may land, and no done follows.
      wr_log.delete();
      ref_mem[32'h200] = 8'h5A;
      ref_mem[32'h201] = 8'h5A;
      issue(0, 32'h200, 0, 8'h5A, 8, 1);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort writes", wr_log.size(), 2);
      chk("abort busy", busy, 0);
      saw_done = 0;
      repeat (10) begin
         if (done === 1'b1 || busy === 1'b1) saw_done = 1;
         @(posedge clk); #1;
      end
      chk("abort no_done", saw_done, 0);
      chk("abort mem_image", mem_diff(), 0);
      $display("abort writes=%0d busy=%0d", wr_log.size(), busy);

      // Start pulsed while busy must be dropped.
      wr_log.delete();
      for (int i = 0; i < 3; i++) ref_mem[32'h300 + i] = 8'h11;
      issue(0, 32'h300, 0, 8'h11, 3, 1);
      @(posedge clk); #1;
      start = 1'b1; op = 1'b1; dst = 32'h0; src = 32'h20; len = 5;
      @(posedge clk); #1;
      start = 1'b0;
      c = 3;
      while (done !== 1'b1 && c < 40) begin @(posedge clk); #1; c++; end
      chk("ignore done_cycle", c, 5);
      saw_done = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (busy === 1'b1) saw_done = 1;
      end
      chk("ignore no_second_op", saw_done, 0);
      chk("ignore writes", wr_log.size(), 3);
      chk("ignore mem_image", mem_diff(), 0);
      $display("ignore_start done_cycle=%0d writes=%0d", c, wr_log.size());

      // Memory trap on the third write stops the fill and reports that code.
      wr_log.delete();
      inj_en = 1'b1; inj_addr = 32'h402; inj_code = 4'd5;
      ref_mem[32'h400] = 8'h77;
      ref_mem[32'h401] = 8'h77;
      issue(0, 32'h400, 0, 8'h77, 6, 1);
      c = 1;
      while (done !== 1'b1 && c < 40) begin @(posedge clk); #1; c++; end
      chk("memtrap done_cycle", c, 5);
      chk("memtrap code", trap_o, 4'd5);
      @(posedge clk); #1;
      inj_en = 1'b0;
      chk("memtrap writes", wr_log.size(), 3);
      chk("memtrap mem_image", mem_diff(), 0);
      $display("mem_trap code=%0d cycles=%0d writes=%0d", trap_o, c, wr_log.size());

      for (int k = 0; k < 40; k++) begin
         pg  = $urandom_range(0, 2);
         lim = pg * 32'h1_0000;
         case ($urandom_range(0, 2))
            0: d = $urandom_range(0, 48);
            1: d = lim - 32'($urandom_range(0, 16));
            default: d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         endcase
         case ($urandom_range(0, 3))
            0: s = $urandom_range(0, 48);
            1: s = lim - 32'($urandom_range(0, 16));
            2: s = d + 32'($urandom_range(0, 4)) - 32'd2;
            default: s = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
         endcase
         case ($urandom_range(0, 15))
            0, 1: l = 0;
            2: l = 32'h8000_0000 + $urandom();
            default: l = $urandom_range(1, 16);
         endcase
         run_op($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), d, s, 8'($urandom), l, pg);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
